// File: rtl/windower_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : windower_pkg
//  Description : Shared types and beat-count helpers for the windower frame
//                sequencer and its output tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package windower_pkg;

  // Input-side sequencer states
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRE_PAD  = 3'd1,
    S_STREAM   = 3'd2,
    S_POST_PAD = 3'd3,
    S_DRAIN    = 3'd4
  } seq_state_t;

  // Image beats per frame
  function automatic int img_beats(input int log2_img_size, input int throughput);
    return (1 << log2_img_size) / throughput;
  endfunction

  // Zero beats inserted at each frame edge
  function automatic int pad_beats(input int padding, input int throughput);
    return padding / throughput;
  endfunction

  // Beats per frame including both pads
  function automatic int total_beats(input int log2_img_size, input int throughput,
                                     input int padding);
    return img_beats(log2_img_size, throughput) + 2 * pad_beats(padding, throughput);
  endfunction

  // Windower outputs per frame that still contain samples from the previous frame
  function automatic int prime_beats(input int window, input int throughput);
    return (window - 1 + throughput - 1) / throughput;
  endfunction

endpackage
`default_nettype wire

// File: rtl/windower_out_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : windower_out_tracker
//  Description : Counts windower output beats within a frame and qualifies
//                each beat with keep/sof/eof, masking priming windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module windower_out_tracker
  import windower_pkg::*;
#(
  parameter int TOTAL_BEATS = 10,
  parameter int PRIME_BEATS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic win_vld_out,
  input  logic drain,
  input  logic clear,
  output logic keep,
  output logic sof,
  output logic eof,
  output logic frame_done
);

  localparam int OCNT_W = $clog2(TOTAL_BEATS + 1);
  localparam logic [OCNT_W-1:0] C_OCNT_LAST = OCNT_W'(TOTAL_BEATS - 1);
  localparam logic [OCNT_W-1:0] C_OCNT_PRIME = OCNT_W'(PRIME_BEATS);

  logic [OCNT_W-1:0] ocnt_q;
  logic [OCNT_W-1:0] ocnt_d;
  logic              frame_done_q;

  // Output-beat position: cleared on abort, pinned to 0 while draining, wraps per frame
  always_comb begin
    ocnt_d = ocnt_q;
    if (clear || drain) begin
      ocnt_d = '0;
    end else if (win_vld_out) begin
      ocnt_d = (ocnt_q == C_OCNT_LAST) ? '0 : ocnt_q + OCNT_W'(1);
    end
  end

  // Beat-position and frame-done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocnt_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ocnt_q       <= ocnt_d;
      frame_done_q <= eof;
    end
  end

  // Qualifiers are combinational so they line up with the windower data_out
  assign keep       = win_vld_out && (ocnt_q >= C_OCNT_PRIME) && !drain;
  assign sof        = keep && (ocnt_q == C_OCNT_PRIME);
  assign eof        = keep && (ocnt_q == C_OCNT_LAST);
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: rtl/windower_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : windower_seq_ctrl
//  Description : Cuts a ready/valid sample stream into padded frames for the
//                windower line buffer and qualifies its output windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module windower_seq_ctrl
  import windower_pkg::*;
#(
  parameter int NO_CH         = 16,
  parameter int LOG2_IMG_SIZE = 10,
  parameter int THROUGHPUT    = 1,
  parameter int WINDOW        = 3,
  parameter int PADDING       = 1,
  parameter int DRAIN_CYC     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        abort,
  input  logic                        src_vld,
  output logic                        src_rdy,
  input  logic [NO_CH*THROUGHPUT-1:0] src_data,
  output logic                        win_vld_in,
  output logic [NO_CH*THROUGHPUT-1:0] win_data_in,
  input  logic                        win_vld_out,
  output logic                        keep,
  output logic                        sof,
  output logic                        eof,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int IMG_BEATS   = img_beats(LOG2_IMG_SIZE, THROUGHPUT);
  localparam int PAD_BEATS   = pad_beats(PADDING, THROUGHPUT);
  localparam int TOTAL_BEATS = total_beats(LOG2_IMG_SIZE, THROUGHPUT, PADDING);
  localparam int PRIME_BEATS = prime_beats(WINDOW, THROUGHPUT);
  localparam int DW          = NO_CH * THROUGHPUT;
  localparam int CNT_W       = $clog2(TOTAL_BEATS + 1);
  localparam int DCNT_W      = $clog2(DRAIN_CYC + 1);

  localparam logic [CNT_W-1:0]  C_IMG_LAST   = CNT_W'(IMG_BEATS - 1);
  localparam logic [CNT_W-1:0]  C_PAD_LAST   = CNT_W'((PAD_BEATS > 0) ? PAD_BEATS - 1 : 0);
  localparam logic [DCNT_W-1:0] C_DRAIN_LAST = DCNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  generate
    if ((PADDING % THROUGHPUT) != 0 || PRIME_BEATS >= TOTAL_BEATS) begin : g_param_err
      $error("windower_seq_ctrl: PADDING must be a multiple of THROUGHPUT and priming must fit in a frame");
    end
  endgenerate

  seq_state_t        state_q;
  seq_state_t        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [DCNT_W-1:0] dcnt_q;
  logic [DCNT_W-1:0] dcnt_d;
  logic              win_vld_q;
  logic              win_vld_d;
  logic [DW-1:0]     win_data_q;
  logic [DW-1:0]     win_data_d;
  logic              hs;

  // Ready only in STREAM; an abort in the same cycle refuses the sample
  assign src_rdy = (state_q == S_STREAM) && !abort;
  assign hs      = src_vld && src_rdy;
  assign busy    = (state_q != S_IDLE);

  // Next-state, beat counters and the registered windower input beat
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dcnt_d     = dcnt_q;
    win_vld_d  = 1'b0;
    win_data_d = win_data_q;
    if (abort) begin
      state_d = S_DRAIN;
      cnt_d   = '0;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // The sample that triggers a start is consumed later, in STREAM
          if (en && src_vld) begin
            cnt_d   = '0;
            state_d = (PAD_BEATS == 0) ? S_STREAM : S_PRE_PAD;
          end
        end
        S_PRE_PAD: begin
          win_vld_d  = 1'b1;
          win_data_d = '0;
          if (cnt_q == C_PAD_LAST) begin
            cnt_d   = '0;
            state_d = S_STREAM;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STREAM: begin
          if (hs) begin
            win_vld_d  = 1'b1;
            win_data_d = src_data;
            if (cnt_q == C_IMG_LAST) begin
              cnt_d   = '0;
              state_d = (PAD_BEATS == 0) ? S_IDLE : S_POST_PAD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_POST_PAD: begin
          win_vld_d  = 1'b1;
          win_data_d = '0;
          if (cnt_q == C_PAD_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == C_DRAIN_LAST) begin
            dcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            dcnt_d = dcnt_q + DCNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  // Sequencer state and windower input registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dcnt_q     <= '0;
      win_vld_q  <= 1'b0;
      win_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dcnt_q     <= dcnt_d;
      win_vld_q  <= win_vld_d;
      win_data_q <= win_data_d;
    end
  end

  assign win_vld_in  = win_vld_q;
  assign win_data_in = win_data_q;

  windower_out_tracker #(
    .TOTAL_BEATS (TOTAL_BEATS),
    .PRIME_BEATS (PRIME_BEATS)
  ) u_out_tracker (
    .clk         (clk),
    .rst         (rst),
    .win_vld_out (win_vld_out),
    .drain       (state_q == S_DRAIN),
    .clear       (abort),
    .keep        (keep),
    .sof         (sof),
    .eof         (eof),
    .frame_done  (frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_windower_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_windower_seq_ctrl
//  Description : Directed self-checking bench for windower_seq_ctrl with a
//                2-cycle windower stand-in (padded and unpadded builds).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_windower_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        abort = 1'b0;
  logic        abort0 = 1'b0;
  logic        src_vld = 1'b0;
  logic        src_vld0 = 1'b0;
  logic [15:0] src_data = '0;
  logic [15:0] src_data0 = '0;
  logic        src_rdy, src_rdy0;
  logic        win_vld_in, win_vld_in0;
  logic [15:0] win_data_in, win_data_in0;
  logic        win_vld_out, win_vld_out0;
  logic        keep, sof, eof, frame_done, busy;
  logic        keep0, sof0, eof0, frame_done0, busy0;
  logic [1:0]  dly, dly0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Padded build: 8 samples + 1 pad each side -> 10 beats, 2 priming
  windower_seq_ctrl #(
    .NO_CH(16), .LOG2_IMG_SIZE(3), .THROUGHPUT(1), .WINDOW(3), .PADDING(1), .DRAIN_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .src_vld(src_vld), .src_rdy(src_rdy),
    .src_data(src_data), .win_vld_in(win_vld_in), .win_data_in(win_data_in),
    .win_vld_out(win_vld_out), .keep(keep), .sof(sof), .eof(eof),
    .frame_done(frame_done), .busy(busy)
  );

  // Unpadded build: 8 beats per frame, 2 priming
  windower_seq_ctrl #(
    .NO_CH(16), .LOG2_IMG_SIZE(3), .THROUGHPUT(1), .WINDOW(3), .PADDING(0), .DRAIN_CYC(4)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .abort(abort0), .src_vld(src_vld0), .src_rdy(src_rdy0),
    .src_data(src_data0), .win_vld_in(win_vld_in0), .win_data_in(win_data_in0),
    .win_vld_out(win_vld_out0), .keep(keep0), .sof(sof0), .eof(eof0),
    .frame_done(frame_done0), .busy(busy0)
  );

  // Windower stand-in: vld_out is vld_in delayed two cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dly  <= '0;
      dly0 <= '0;
    end else begin
      dly  <= {dly[0], win_vld_in};
      dly0 <= {dly0[0], win_vld_in0};
    end
  end
  assign win_vld_out  = dly[1];
  assign win_vld_out0 = dly0[1];

  // Cumulative event log, sampled mid-cycle
  logic [15:0] beats  [0:255];
  logic [15:0] beats0 [0:255];
  int n_beats = 0, n_vout = 0, n_keep = 0, n_sof = 0, n_eof = 0, n_fd = 0, n_fd_ok = 0;
  int n_hs = 0, n_idle = 0, n_hold_bad = 0, last_sof = 0, last_eof = 0;
  int n0_beats = 0, n0_vout = 0, n0_keep = 0, n0_sof = 0, n0_eof = 0, last0_sof = 0, last0_eof = 0;
  logic        prev_eof = 1'b0;
  logic [15:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_eof  = 1'b0;
      prev_data = win_data_in;
    end else begin
      if (win_vld_in) begin
        if (n_beats < 256) beats[n_beats] = win_data_in;
        n_beats++;
      end else if (win_data_in != prev_data) begin
        n_hold_bad++;
      end
      if (src_vld && src_rdy) n_hs++;
      if (!busy) n_idle++;
      if (keep) n_keep++;
      if (sof) begin n_sof++; last_sof = n_vout; end
      if (eof) begin n_eof++; last_eof = n_vout; end
      if (frame_done) begin n_fd++; if (prev_eof) n_fd_ok++; end
      if (win_vld_out) n_vout++;
      prev_eof  = eof;
      prev_data = win_data_in;
      if (win_vld_in0) begin
        if (n0_beats < 256) beats0[n0_beats] = win_data_in0;
        n0_beats++;
      end
      if (keep0) n0_keep++;
      if (sof0) begin n0_sof++; last0_sof = n0_vout; end
      if (eof0) begin n0_eof++; last0_eof = n0_vout; end
      if (win_vld_out0) n0_vout++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded)
  task automatic send(input bit sel, input logic [15:0] d);
    bit hs;
    int budget;
    if (sel) begin src_vld0 = 1'b1; src_data0 = d; end
    else     begin src_vld  = 1'b1; src_data  = d; end
    hs = 1'b0;
    budget = 0;
    while (!hs && budget < 50) begin
      @(negedge clk);
      hs = sel ? src_rdy0 : src_rdy;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!hs) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Eight samples first..first+7 on the padded DUT, optional idle gap after each
  task automatic frame8(input logic [15:0] first, input bit gappy);
    for (int i = 0; i < 8; i++) begin
      send(1'b0, first + 16'(i));
      if (gappy) begin
        src_vld = 1'b0;
        wait_cyc(1);
      end
    end
    src_vld = 1'b0;
  endtask

  // Check one padded frame's beats starting at log index b: 0, first..first+7, 0
  task automatic chk_frame_data(input string tag, input int b, input logic [15:0] first);
    for (int i = 0; i < 10; i++)
      chk(tag, 32'(beats[b + i]), (i == 0 || i == 9) ? 32'd0 : 32'(first + 16'(i - 1)));
  endtask

  int bb, bv, bk, bs, be, bf, bfo, bh, bi, bhb;
  task automatic snap;
    bb = n_beats; bv = n_vout; bk = n_keep; bs = n_sof; be = n_eof;
    bf = n_fd; bfo = n_fd_ok; bh = n_hs; bi = n_idle; bhb = n_hold_bad;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    wait_cyc(2);
    chk("rst_src_rdy", 32'(src_rdy), 0);
    chk("rst_win_vld_in", 32'(win_vld_in), 0);
    chk("rst_win_data_in", 32'(win_data_in), 0);
    chk("rst_keep", 32'(keep), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    en  = 1'b1;
    wait_cyc(2);

    // ---------------- steady frame ----------------
    snap();
    frame8(16'd1, 1'b0);
    wait_cyc(8);
    chk("steady_beats", 32'(n_beats - bb), 10);
    chk_frame_data("steady_data", bb, 16'd1);
    chk("steady_hs", 32'(n_hs - bh), 8);
    chk("steady_keep", 32'(n_keep - bk), 8);
    chk("steady_sof", 32'(n_sof - bs), 1);
    chk("steady_eof", 32'(n_eof - be), 1);
    chk("steady_sof_pos", 32'(last_sof - bv), 2);
    chk("steady_eof_pos", 32'(last_eof - bv), 9);
    chk("steady_fd", 32'(n_fd - bf), 1);
    chk("steady_fd_after_eof", 32'(n_fd_ok - bfo), 1);
    chk("steady_idle_busy", 32'(busy), 0);

    // ---------------- gappy source ----------------
    snap();
    frame8(16'd21, 1'b1);
    wait_cyc(8);
    chk("gappy_hs", 32'(n_hs - bh), 8);
    chk("gappy_beats", 32'(n_beats - bb), 10);
    chk_frame_data("gappy_data", bb, 16'd21);
    chk("gappy_hold", 32'(n_hold_bad - bhb), 0);
    chk("gappy_keep", 32'(n_keep - bk), 8);
    chk("gappy_eof", 32'(n_eof - be), 1);

    // ---------------- back-to-back frames ----------------
    snap();
    send(1'b0, 16'd101);
    bi = n_idle;
    for (int i = 1; i < 16; i++) send(1'b0, 16'd101 + 16'(i));
    chk("b2b_idle_gap", 32'(n_idle - bi), 1);
    src_vld = 1'b0;
    wait_cyc(8);
    chk("b2b_beats", 32'(n_beats - bb), 20);
    chk_frame_data("b2b_data1", bb, 16'd101);
    chk_frame_data("b2b_data2", bb + 10, 16'd109);
    chk("b2b_keep", 32'(n_keep - bk), 16);
    chk("b2b_sof", 32'(n_sof - bs), 2);
    chk("b2b_eof", 32'(n_eof - be), 2);
    chk("b2b_sof2_pos", 32'(last_sof - bv), 12);

    // ---------------- abort mid-STREAM ----------------
    snap();
    for (int i = 0; i < 4; i++) send(1'b0, 16'd201 + 16'(i));
    abort = 1'b1;
    src_vld = 1'b1;
    src_data = 16'd205;
    #1;
    chk("abort_src_rdy", 32'(src_rdy), 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    src_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_busy", 32'(busy), 1);
      chk("drain_keep", 32'(keep), 0);
      chk("drain_win_vld_in", 32'(win_vld_in), 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain_exit_busy", 32'(busy), 0);
    chk("abort_hs", 32'(n_hs - bh), 4);
    wait_cyc(2);
    snap();
    frame8(16'd301, 1'b0);
    wait_cyc(8);
    chk("post_abort_sof_pos", 32'(last_sof - bv), 2);
    chk("post_abort_keep", 32'(n_keep - bk), 8);
    chk("post_abort_eof", 32'(n_eof - be), 1);
    chk_frame_data("post_abort_data", bb, 16'd301);

    // ---------------- PADDING=0 build ----------------
    begin
      int b0b, b0v, b0k, b0e;
      b0b = n0_beats; b0v = n0_vout; b0k = n0_keep; b0e = n0_eof;
      src_vld0 = 1'b1;
      src_data0 = 16'd401;
      wait_cyc(1);
      chk("nopad_direct_stream", 32'(src_rdy0), 1);
      for (int i = 0; i < 8; i++) send(1'b1, 16'd401 + 16'(i));
      src_vld0 = 1'b0;
      wait_cyc(8);
      chk("nopad_beats", 32'(n0_beats - b0b), 8);
      for (int i = 0; i < 8; i++)
        chk("nopad_data", 32'(beats0[b0b + i]), 32'(16'd401 + 16'(i)));
      chk("nopad_keep", 32'(n0_keep - b0k), 6);
      chk("nopad_sof_pos", 32'(last0_sof - b0v), 2);
      chk("nopad_eof_pos", 32'(last0_eof - b0v), 7);
      chk("nopad_eof", 32'(n0_eof - b0e), 1);
    end

    // ---------------- async reset mid-POST_PAD ----------------
    for (int i = 0; i < 8; i++) send(1'b0, 16'd501 + 16'(i));
    src_vld = 1'b0;
    chk("postpad_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_win_vld_in", 32'(win_vld_in), 0);
    chk("arst_win_data_in", 32'(win_data_in), 0);
    chk("arst_src_rdy", 32'(src_rdy), 0);
    chk("arst_keep", 32'(keep), 0);
    chk("arst_sof", 32'(sof), 0);
    chk("arst_eof", 32'(eof), 0);
    chk("arst_frame_done", 32'(frame_done), 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    chk("arst_release_idle", 32'(busy), 0);
    snap();
    frame8(16'd601, 1'b0);
    wait_cyc(8);
    chk("arst_next_beats", 32'(n_beats - bb), 10);
    chk_frame_data("arst_next_data", bb, 16'd601);
    chk("arst_next_keep", 32'(n_keep - bk), 8);
    chk("arst_next_sof_pos", 32'(last_sof - bv), 2);
    chk("arst_next_eof_pos", 32'(last_eof - bv), 9);
    chk("arst_next_fd", 32'(n_fd - bf), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/windower_seq_ctrl.md
Name: windower_seq_ctrl

Overview:
- Frame sequencer placed in front of, and alongside, the `windower` line buffer in the modulation-classifier conv pipeline.
- Accepts a ready/valid sample stream and cuts it into frames of 2^LOG2_IMG_SIZE samples.
- Inserts PADDING zero-beats before and after each frame and drives the windower's vld_in/data_in.
- Watches the windower's vld_out and generates per-window qualifiers (keep/sof/eof) that mask priming windows which straddle frames.

Parameters:
- NO_CH, 16, bits per sample lane.
- LOG2_IMG_SIZE, 10, log2 of samples per frame.
- THROUGHPUT, 1, samples per beat.
- WINDOW, 3, window length in samples.
- PADDING, 1, zero samples inserted at each frame edge.
- DRAIN_CYC, 4, cycles during which windower outputs are suppressed after abort.
- Derived: IMG_BEATS = 2^LOG2_IMG_SIZE/THROUGHPUT.
- Derived: PAD_BEATS = PADDING/THROUGHPUT.
- Derived: TOTAL_BEATS = IMG_BEATS + 2*PAD_BEATS.
- Derived: PRIME_BEATS = ceil((WINDOW-1)/THROUGHPUT).
- Elaboration error if PADDING%THROUGHPUT != 0 or PRIME_BEATS >= TOTAL_BEATS.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  permits starting a new frame.
- abort  in  1  synchronous frame abort.
- src_vld  in  1  upstream sample valid.
- src_rdy  out  1  upstream ready.
- src_data  in  NO_CH*THROUGHPUT  upstream samples; lane 0 in the LSBs.
- win_vld_in  out  1  to windower vld_in.
- win_data_in  out  NO_CH*THROUGHPUT  to windower data_in.
- win_vld_out  in  1  from windower vld_out.
- keep  out  1  current windower output beat is a valid window.
- sof  out  1  first kept beat of a frame.
- eof  out  1  last kept beat of a frame.
- frame_done  out  1  one-cycle pulse, one cycle after eof.
- busy  out  1  input FSM not in IDLE.

Behaviour:
- Reset values: state IDLE, both counters 0, win_vld_in=0, win_data_in=0, frame_done=0. src_rdy, keep, sof, eof and busy are all 0 in reset.
- Input FSM states: IDLE, PRE_PAD, STREAM, POST_PAD, DRAIN.
- IDLE -> PRE_PAD when en && src_vld; no sample is consumed on this transition. If PAD_BEATS=0, go straight to STREAM.
- PRE_PAD: emit one zero beat per cycle (win_vld_in=1, win_data_in=0). After PAD_BEATS beats, go to STREAM.
- STREAM: src_rdy=1, decoded from the registered state. Each src_vld&&src_rdy produces win_vld_in=1 and win_data_in=src_data on the next cycle.
- STREAM gaps: when there is no handshake, win_vld_in=0 and win_data_in holds its last value.
- STREAM exit: after the IMG_BEATS-th handshake, go to POST_PAD; src_rdy drops in the same cycle as the registered transition.
- POST_PAD: emit PAD_BEATS zero beats, then go to IDLE. A new frame may start from IDLE on the next cycle.
- src_rdy=1 only in STREAM. busy=1 in every state except IDLE.
- Output tracker: counter ocnt (0..TOTAL_BEATS-1) increments on each win_vld_out and wraps to 0 after TOTAL_BEATS-1. It is independent of the input FSM, so frames may overlap across the windower latency.
- keep = win_vld_out && ocnt >= PRIME_BEATS && !(state==DRAIN). This is combinational, aligned with windower data_out.
- sof = keep && ocnt==PRIME_BEATS.
- eof = keep && ocnt==TOTAL_BEATS-1.
- Kept windows per frame = TOTAL_BEATS-PRIME_BEATS.
- abort, from any state: next state DRAIN, input counter cleared, win_vld_in=0, ocnt cleared.
- DRAIN: lasts DRAIN_CYC cycles. ocnt is held at 0, keep/sof/eof are forced 0, then go to IDLE.
- abort asserted while already in DRAIN restarts the drain count.
- abort has priority over every transition and over a handshake in the same cycle; the sample is not accepted and src_rdy=0 that cycle.
- en deasserted mid-frame has no effect; it gates only IDLE->PRE_PAD.
- Counter widths are $clog2(TOTAL_BEATS+1); no counter overflow is possible.
- An asynchronous rst mid-frame returns all state to the reset values immediately.

Decomposition:
- Package windower_pkg holds:
  - the FSM state enum (seq_state_t);
  - functions computing IMG_BEATS, PAD_BEATS, TOTAL_BEATS and PRIME_BEATS from the parameters.
- One sub-module: windower_out_tracker, which owns ocnt, keep/sof/eof and frame_done. It is instantiated with a drain input.

Test Plan (LOG2_IMG_SIZE=3, THROUGHPUT=1, WINDOW=3, PADDING=1, DRAIN_CYC=4, so TOTAL_BEATS=10, PRIME_BEATS=2):
- Steady frame: en=1, src_vld=1 with samples 1..8, loop win_vld_out = win_vld_in delayed 2 cycles.
  - win_data_in sequence must be 0,1..8,0 (10 beats).
  - keep high on beats 2..9 (8 windows), sof on beat 2, eof on beat 9, frame_done the cycle after eof.
- Gappy source: src_vld toggles 1/0 during STREAM.
  - Exactly 8 handshakes; win_vld_in low in gap cycles; win_data_in unchanged in gaps.
  - keep count still 8 per frame.
- Back-to-back frames: src_vld held high for 16 samples.
  - Exactly one IDLE cycle between frames.
  - Second frame sof on the 13th win_vld_out; 16 keeps total, 2 eofs.
- Abort mid-STREAM after sample 4:
  - src_rdy=0 in the abort cycle, busy=1 for 4 DRAIN cycles, no keep during DRAIN.
  - The next frame produces a clean sof after 2 priming beats.
- PADDING=0 build: IDLE goes directly to STREAM; 8 input beats give keep on beats 2..7 (6 windows).
- Async rst asserted mid-POST_PAD:
  - All outputs 0 in the same cycle; state IDLE after release; next frame behaves as in the steady-frame case.
